// File: rtl/jk_bank_ctrl.sv
// Command-driven sequencer for a bank of JK flip-flops: converts SR/T/D style
// commands (single-cycle or repeated) into per-bit J/K drive for the internal bank.
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_rem;
  logic             r_err;

  logic             w_accept;
  logic             w_run_op;
  logic [WIDTH-1:0] w_t;
  logic             w_carry;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_run_op  = (cmd_op == 3'b101) || (cmd_op == 3'b110);

  // Counter toggle vector: bit i toggles when all lower bits are 1.
  always_comb begin
    w_t     = '0;
    w_carry = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_t[i]  = w_carry;
      w_carry = w_carry & r_q[i];
    end
  end

  always_comb begin
    w_next = r_state;
    w_j    = '0;
    w_k    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_run_op ? S_RUN : S_EXEC;
      end
      S_EXEC: begin
        case (r_op)
          3'b001: w_j = r_data;
          3'b010: w_k = r_data;
          3'b011: begin
            w_j = r_data;
            w_k = r_data;
          end
          3'b100: begin
            w_j = r_data;
            w_k = ~r_data;
          end
          default: ;
        endcase
        w_next = S_DONE;
      end
      S_RUN: begin
        if (r_rem != '0) begin
          w_j = (r_op == 3'b101) ? w_t : r_data;
          w_k = w_j;
          if (r_rem == CNT_W'(1)) w_next = S_DONE;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_data  <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_q     <= (w_j & ~r_q) | (~w_k & r_q);
      if (w_accept) begin
        r_op   <= cmd_op;
        r_data <= cmd_data;
        r_rem  <= cmd_len;
      end else if (r_state == S_RUN && r_rem != '0) begin
        r_rem <= r_rem - CNT_W'(1);
      end
      if (r_state == S_EXEC && r_op == 3'b111) r_err <= 1'b1;
    end
  end

  assign j    = rst ? '0 : w_j;
  assign k    = rst ? '0 : w_k;
  assign q    = r_q;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE) && !rst;
  assign err  = r_err;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed + randomized bench for jk_bank_ctrl; expected bank state comes from
// an arithmetic model of each command (OR/AND-NOT/XOR/load/add).
module tb_jk_bank_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_len;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] m_q   = '0;
  logic       m_err = 1'b0;

  jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command from a negedge in IDLE and follow it to its done pulse.
  task automatic send(input logic [2:0] op, input logic [3:0] data,
                      input logic [7:0] len, input bit noisy);
    logic [3:0] ej;
    logic [3:0] ek;
    logic [3:0] q0;
    bit         run;
    int         lat;
    int         exp_lat;
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = noisy;
    if (noisy) begin
      cmd_op   = 3'($urandom);
      cmd_data = 4'($urandom);
      cmd_len  = 8'($urandom);
    end
    run     = (op == 3'b101) || (op == 3'b110);
    exp_lat = (run && len != 0) ? int'(len) : 1;
    ej = '0;
    ek = '0;
    case (op)
      3'b001: ej = data;
      3'b010: ek = data;
      3'b011: begin ej = data; ek = data; end
      3'b100: begin ej = data; ek = ~data; end
      3'b101: if (len != 0) begin ej = m_q ^ (m_q + 4'd1); ek = ej; end
      3'b110: if (len != 0) begin ej = data; ek = data; end
      default: ;
    endcase
    check("first_j", j, ej);
    check("first_k", k, ek);
    check("busy_in_cmd", busy, 1);
    check("ready_in_cmd", cmd_ready, 0);
    q0  = m_q;
    lat = 0;
    while (done !== 1'b1 && lat < exp_lat + 4) begin
      if (op == 3'b101) check("count_walk", q, 4'(q0 + 4'(lat)));
      @(negedge clk);
      lat++;
    end
    cmd_valid = 1'b0;
    case (op)
      3'b001: m_q = m_q | data;
      3'b010: m_q = m_q & ~data;
      3'b011: m_q = m_q ^ data;
      3'b100: m_q = data;
      3'b101: m_q = m_q + len[3:0];
      3'b110: if (len[0]) m_q = m_q ^ data;
      3'b111: m_err = 1'b1;
      default: ;
    endcase
    check("done_seen", done, 1);
    check("done_latency", lat, exp_lat);
    check("q_at_done", q, m_q);
    check("err_at_done", err, m_err);
    check("jk_zero_in_done", {j, k}, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after", cmd_ready, 1);
    check("busy_after", busy, 0);
    check("q_after", q, m_q);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_data  = 4'hF;
    cmd_len   = 8'd0;

    // Reset with a command held on the bus
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_q", q, 0);
      check("rst_ready", cmd_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_jk", {j, k}, 0);
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("ready_after_rst", cmd_ready, 1);

    // SR and T conversions
    send(3'b001, 4'b1010, 8'd0, 1'b0);
    check("set_mask_q", q, 4'b1010);
    send(3'b011, 4'b0110, 8'd0, 1'b0);
    check("tog_mask_q", q, 4'b1100);

    // D load then counter with wrap
    send(3'b100, 4'b0111, 8'd0, 1'b0);
    send(3'b101, 4'b0000, 8'd10, 1'b0);
    check("count_wrap_q", q, 4'b0001);

    // Zero-length count and odd-length toggle run
    send(3'b101, 4'b1111, 8'd0, 1'b0);
    check("count_len0_q", q, 4'b0001);
    send(3'b110, 4'b0001, 8'd3, 1'b0);
    check("tog_run_q", q, 4'b0000);

    // Reserved opcode, with cmd_valid noise while busy
    send(3'b111, 4'b1111, 8'd0, 1'b1);
    check("reserved_err", err, 1);
    send(3'b001, 4'b0011, 8'd0, 1'b1);
    send(3'b110, 4'b1001, 8'd4, 1'b1);
    check("err_sticky", err, 1);

    // Reset in the middle of a long count
    send(3'b100, 4'b0000, 8'd0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 3'b101;
    cmd_len   = 8'd20;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("pre_rst_q", q, 4'd4);
    rst = 1'b1;
    #1;
    check("midrst_ready", cmd_ready, 0);
    check("midrst_jk", {j, k}, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst   = 1'b0;
    m_q   = '0;
    m_err = 1'b0;
    #1;
    check("abort_q", q, 0);
    check("abort_busy", busy, 0);
    check("abort_err", err, 0);
    check("abort_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end

    // Randomized command stream
    for (int n = 0; n < 40; n++) begin
      send(3'($urandom_range(0, 7)), 4'($urandom), 8'($urandom_range(0, 12)),
           1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
